// File: rtl/clk_div_pkg.sv
// Shared types for the clock divider controller: FSM state encoding and default counter width.
package clk_div_pkg;

   localparam int unsigned CNT_W_DEFAULT = 8;

   // Bit 2 = busy, bit 1 = cfg_ready, so both outputs come straight from the state flops.
   typedef enum logic [2:0] {
      IDLE = 3'b010,
      RUN  = 3'b110,
      PEND = 3'b100,
      STOP = 3'b101
   } clk_div_state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake bundle for clk_div_ctrl (valid/ready with enable and divisor payload).
interface clk_div_ctrl_if
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
);

   logic             cfg_valid;
   logic             cfg_ready;
   logic             cfg_en;
   logic [CNT_W-1:0] cfg_div;

   modport master (output cfg_valid, output cfg_en, output cfg_div, input  cfg_ready);
   modport slave  (input  cfg_valid, input  cfg_en, input  cfg_div, output cfg_ready);

endinterface

// File: rtl/clk_div_core.sv
// Half-period counter with registered divided clock and rising-edge tick.
module clk_div_core #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             run,
   input  logic             clear,
   input  logic [CNT_W-1:0] div_q,
   output logic             clk_out,
   output logic             div_tick,
   output logic             wrap
);

   logic [CNT_W-1:0] count;

   // wrap marks the edge on which clk_out toggles; the controller keys its updates off it.
   assign wrap = run && (count == div_q - CNT_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (!rst_n || clear || !run) begin
         count    <= '0;
         clk_out  <= 1'b0;
         div_tick <= 1'b0;
      end else if (wrap) begin
         count    <= '0;
         clk_out  <= ~clk_out;
         div_tick <= ~clk_out;
      end else begin
         count    <= count + CNT_W'(1);
         div_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock divider controller: config handshake, FSM, pending-divisor register around clk_div_core.
// Optional feature: define CLK_DIV_CTRL_ERR_EN to reject cfg_div==0 with a cfg_err strobe.
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic           clk_in,
   input  logic           rst_n,
   clk_div_ctrl_if.slave  cfg,
   output logic           clk_out,
   output logic           div_tick,
   output logic           busy
`ifdef CLK_DIV_CTRL_ERR_EN
   ,
   output logic           cfg_err
`endif
);

   clk_div_state_e   state;
   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] pend_div;
   logic [CNT_W-1:0] req_div;
   logic             xfer;
   logic             div_zero;
   logic             div_bad;
   logic             run;
   logic             clear;
   logic             wrap;
   logic             fall;

   assign xfer     = cfg.cfg_valid && cfg.cfg_ready;
   assign div_zero = (cfg.cfg_div == '0);

`ifdef CLK_DIV_CTRL_ERR_EN
   assign div_bad = div_zero;
   assign req_div = cfg.cfg_div;
`else
   assign div_bad = 1'b0;
   assign req_div = div_zero ? CNT_W'(1) : cfg.cfg_div;
`endif

   assign cfg.cfg_ready = state[1];
   assign busy          = state[2];
   assign run           = state[2];
   assign fall          = wrap && clk_out;

   // Stopping while low must also squash a 0->1 toggle that would land on the same edge.
   assign clear = (state == RUN) && xfer && !cfg.cfg_en && !clk_out;

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state    <= IDLE;
         div_q    <= CNT_W'(1);
         pend_div <= CNT_W'(1);
`ifdef CLK_DIV_CTRL_ERR_EN
         cfg_err  <= 1'b0;
`endif
      end else begin
`ifdef CLK_DIV_CTRL_ERR_EN
         cfg_err <= xfer && cfg.cfg_en && div_bad;
`endif
         unique case (state)
            IDLE: begin
               if (xfer && cfg.cfg_en && !div_bad) begin
                  div_q <= req_div;
                  state <= RUN;
               end
            end
            RUN: begin
               if (xfer) begin
                  if (cfg.cfg_en) begin
                     if (!div_bad) begin
                        pend_div <= req_div;
                        state    <= PEND;
                     end
                  end else begin
                     // A fall on this very edge already completes the high phase.
                     state <= (clk_out && !fall) ? STOP : IDLE;
                  end
               end
            end
            PEND: begin
               if (fall) begin
                  div_q <= pend_div;
                  state <= RUN;
               end
            end
            STOP: begin
               if (fall) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   clk_div_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .run      (run),
      .clear    (clear),
      .div_q    (div_q),
      .clk_out  (clk_out),
      .div_tick (div_tick),
      .wrap     (wrap)
   );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl; expected waveforms are hand-derived per edge.
module tb_clk_div_ctrl;

   logic clk_in;
   logic rst_n;
   logic clk_out;
   logic div_tick;
   logic busy;
`ifdef CLK_DIV_CTRL_ERR_EN
   logic cfg_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   clk_div_ctrl_if #(.CNT_W(8)) cfg ();

   clk_div_ctrl #(.CNT_W(8)) dut (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .cfg      (cfg),
      .clk_out  (clk_out),
      .div_tick (div_tick),
      .busy     (busy)
`ifdef CLK_DIV_CTRL_ERR_EN
      ,
      .cfg_err  (cfg_err)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps n negedges; bit (n-1-i) of the patterns is the expectation after the i-th edge.
   task automatic wave(input string tag, input int n, input logic [15:0] exp_clk,
                       input logic [15:0] exp_tick);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_in);
         check($sformatf("%s[%0d]", tag, i), {30'd0, clk_out, div_tick},
               {30'd0, exp_clk[n-1-i], exp_tick[n-1-i]});
      end
   endtask

   task automatic xfer(input string tag, input logic en, input logic [7:0] div);
      check({tag, "_ready"}, 32'(cfg.cfg_ready), 32'd1);
      cfg.cfg_valid = 1'b1;
      cfg.cfg_en    = en;
      cfg.cfg_div   = div;
      @(negedge clk_in);
      cfg.cfg_valid = 1'b0;
   endtask

   initial begin
      rst_n         = 1'b0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_en    = 1'b0;
      cfg.cfg_div   = 8'd0;
      repeat (2) @(negedge clk_in);
      check("rst_clk_out", 32'(clk_out), 32'd0);
      check("rst_tick", 32'(div_tick), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cfg.cfg_ready), 32'd1);
`ifdef CLK_DIV_CTRL_ERR_EN
      check("rst_err", 32'(cfg_err), 32'd0);
`endif
      rst_n = 1'b1;

      // div=2: first rise 2 edges after acceptance, period 4, one tick per period.
      xfer("d2", 1'b1, 8'd2);
      check("d2_busy", 32'(busy), 32'd1);
      check("d2_clk0", 32'(clk_out), 32'd0);
      wave("d2", 8, 16'b01100110, 16'b01000100);

      // Request div=3 while high: stay pending until the fall, then 6-cycle periods.
      wave("d2b", 2, 16'b01, 16'b01);
      xfer("d3", 1'b1, 8'd3);
      check("d3_pend_ready", 32'(cfg.cfg_ready), 32'd0);
      check("d3_pend_clk", 32'(clk_out), 32'd1);
      wave("d3_fall", 1, 16'b0, 16'b0);
      check("d3_run_ready", 32'(cfg.cfg_ready), 32'd1);
      wave("d3", 12, 16'b001110001110, 16'b001000001000);

      // Move to div=4, then stop while clk_out is high.
      xfer("d4", 1'b1, 8'd4);
      check("d4_pend_ready", 32'(cfg.cfg_ready), 32'd0);
      wave("d4", 13, 16'b0111000011110, 16'b0100000010000);
      wave("d4b", 4, 16'b0001, 16'b0001);
      xfer("stop", 1'b0, 8'd4);
      check("stop_busy", 32'(busy), 32'd1);
      check("stop_ready", 32'(cfg.cfg_ready), 32'd0);
      check("stop_clk", 32'(clk_out), 32'd1);
      wave("stop", 3, 16'b110, 16'b000);
      check("stop_idle_busy", 32'(busy), 32'd0);
      check("stop_idle_ready", 32'(cfg.cfg_ready), 32'd1);
      wave("stop_quiet", 8, 16'h0000, 16'h0000);

      // valid held with cfg_en=0 in IDLE: nothing happens.
      cfg.cfg_valid = 1'b1;
      cfg.cfg_en    = 1'b0;
      cfg.cfg_div   = 8'd5;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_in);
         check($sformatf("noop[%0d]", i), {29'd0, busy, clk_out, div_tick}, 32'd0);
      end
      cfg.cfg_valid = 1'b0;

      // cfg_div == 0.
`ifdef CLK_DIV_CTRL_ERR_EN
      xfer("z", 1'b1, 8'd0);
      check("z_err", 32'(cfg_err), 32'd1);
      check("z_busy", 32'(busy), 32'd0);
      @(negedge clk_in);
      check("z_err_clr", 32'(cfg_err), 32'd0);
      check("z_clk", {30'd0, clk_out, busy}, 32'd0);
`else
      xfer("z", 1'b1, 8'd0);
      wave("z", 4, 16'b1010, 16'b1010);
      // Stop while low on an edge that would otherwise raise clk_out.
      xfer("z_stop", 1'b0, 8'd0);
      check("z_stop_state", {29'd0, busy, clk_out, div_tick}, 32'd0);
      wave("z_quiet", 3, 16'b000, 16'b000);
`endif

      // Reset during PEND (5 -> 7 pending), then restart at div=3.
      xfer("d5", 1'b1, 8'd5);
      xfer("d7", 1'b1, 8'd7);
      check("d7_pend_ready", 32'(cfg.cfg_ready), 32'd0);
      wave("d5", 5, 16'b00011, 16'b00010);
      rst_n = 1'b0;
      @(negedge clk_in);
      check("mrst_clk", 32'(clk_out), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_tick", 32'(div_tick), 32'd0);
      check("mrst_ready", 32'(cfg.cfg_ready), 32'd1);
      rst_n = 1'b1;
      xfer("r3", 1'b1, 8'd3);
      wave("r3", 12, 16'b001110001110, 16'b001000001000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
